// File: rtl/spi_byte_master.sv
// Byte-wide SPI master (mode 0, MSB first) with chip-select ownership and a data-ready level.
// Optional SPI_SLOWCLK_EN adds a `slow` input that selects the SLOW_DIV half-period per byte.
module spi_byte_master #(
  parameter int DIV = 2
`ifdef SPI_SLOWCLK_EN
  ,
  parameter int SLOW_DIV = 64
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       wr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dsr,
  output logic       busy,
  input  logic       cs_wr,
  input  logic       cs_val,
`ifdef SPI_SLOWCLK_EN
  input  logic       slow,
`endif
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n,
  output logic [1:0] fsm_state
);

  // Handshake: wr is a request taken only in IDLE on a ce-qualified edge; acceptance clears dsr
  // and raises busy on that same edge, and busy falls on the edge that raises dsr.
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t     state_q;
  logic [7:0] txreg;
  logic [7:0] rxreg;
  logic [2:0] bitcnt;
  logic [7:0] divcnt;
  logic [7:0] half;
  logic [7:0] start_half;

`ifdef SPI_SLOWCLK_EN
  assign start_half = slow ? 8'(SLOW_DIV) : 8'(DIV);
`else
  // Fixed rate: the reload value is a constant and needs no storage.
  assign start_half = 8'(DIV);
  assign half       = 8'(DIV);
`endif

  assign fsm_state = state_q;

  // The MSB leaves on mosi at load time; only bits 6..0 are shifted out afterwards.
  logic unused_txmsb;
  assign unused_txmsb = txreg[7];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      txreg   <= 8'h00;
      rxreg   <= 8'h00;
      bitcnt  <= 3'd0;
      divcnt  <= 8'h00;
`ifdef SPI_SLOWCLK_EN
      half    <= 8'(DIV);
`endif
      dout    <= 8'h00;
      dsr     <= 1'b0;
      busy    <= 1'b0;
      sck     <= 1'b0;
      mosi    <= 1'b1;
      cs_n    <= 1'b1;
    end else if (ce) begin
      if (cs_wr) cs_n <= ~cs_val;
      case (state_q)
        IDLE: begin
          if (wr) begin
            txreg   <= din;
            mosi    <= din[7];
            bitcnt  <= 3'd0;
`ifdef SPI_SLOWCLK_EN
            half    <= start_half;
`endif
            divcnt  <= start_half - 8'd1;
            dsr     <= 1'b0;
            busy    <= 1'b1;
            state_q <= LOW;
          end
        end
        LOW: begin
          if (divcnt != 8'd0) begin
            divcnt <= divcnt - 8'd1;
          end else begin
            sck     <= 1'b1;
            rxreg   <= {rxreg[6:0], miso};
            divcnt  <= half - 8'd1;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (divcnt != 8'd0) begin
            divcnt <= divcnt - 8'd1;
          end else begin
            sck <= 1'b0;
            if (bitcnt == 3'd7) begin
              state_q <= DONE;
            end else begin
              bitcnt  <= bitcnt + 3'd1;
              txreg   <= txreg << 1;
              mosi    <= txreg[6];
              divcnt  <= half - 8'd1;
              state_q <= LOW;
            end
          end
        end
        DONE: begin
          dout    <= rxreg;
          dsr     <= 1'b1;
          busy    <= 1'b0;
          mosi    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: DIV=2 instance with a mode-0 slave model, plus a DIV=1
// instance driven with a 1-of-3 clock enable.
module tb_spi_byte_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       ce = 1'b1, wr = 1'b0, cs_wr = 1'b0, cs_val = 1'b0, slow = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       dsr, busy, sck, mosi, miso, cs_n;
  logic [1:0] fsm_state;

  logic       b_ce = 1'b0, b_wr = 1'b0;
  logic [7:0] b_din = 8'h00;
  logic [7:0] b_dout;
  logic       b_dsr, b_busy, b_sck, b_mosi, b_cs_n;
  logic [1:0] b_state;

  spi_byte_master #(.DIV(2)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .wr(wr), .din(din), .dout(dout), .dsr(dsr),
    .busy(busy), .cs_wr(cs_wr), .cs_val(cs_val),
`ifdef SPI_SLOWCLK_EN
    .slow(slow),
`endif
    .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n), .fsm_state(fsm_state)
  );

  spi_byte_master #(.DIV(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .ce(b_ce), .wr(b_wr), .din(b_din), .dout(b_dout), .dsr(b_dsr),
    .busy(b_busy), .cs_wr(1'b0), .cs_val(1'b0),
`ifdef SPI_SLOWCLK_EN
    .slow(1'b0),
`endif
    .sck(b_sck), .mosi(b_mosi), .miso(1'b0), .cs_n(b_cs_n), .fsm_state(b_state)
  );

  int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mode-0 slave: presents its MSB while sck is low, shifts on each sck fall.
  logic [7:0] slave_byte = 8'h00, slave_sh = 8'h00;
  logic       slave_ld = 1'b0;
  always @(negedge sck or posedge slave_ld) begin
    if (slave_ld) slave_sh <= slave_byte;
    else          slave_sh <= {slave_sh[6:0], 1'b0};
  end
  assign miso = slave_sh[7];

  logic [7:0] a_cap = 8'h00, b_cap = 8'h00;
  always @(posedge sck)   a_cap <= {a_cap[6:0], mosi};
  always @(posedge b_sck) b_cap <= {b_cap[6:0], b_mosi};

  // ce-edge counters used to measure latency from acceptance.
  int edge_cnt = 0, b_edge_cnt = 0, acc_a = 0, b_acc = 0;
  logic b_ce_seen = 1'b0;
  always @(posedge clk) begin
    if (reset_n && ce)   edge_cnt++;
    if (reset_n && b_ce) b_edge_cnt++;
    b_ce_seen = b_ce;
  end

  int b_phase = 0;
  always @(negedge clk) begin
    b_phase = (b_phase == 2) ? 0 : b_phase + 1;
    b_ce = (b_phase == 0);
  end

  logic [7:0] exp_q[$];
  logic [7:0] mosi_q[$];
  logic       dsr_prev = 1'b0, b_sck_prev = 1'b0;
  int         b_viol = 0, dsr_rises = 0;

  // Scoreboard: each rising dsr retires one queued transfer.
  always @(negedge clk) begin
    if (dsr === 1'b1 && dsr_prev !== 1'b1) begin
      dsr_rises++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_dsr", 32'd1, 32'd0);
      end else begin
        check("sb_dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
        check("sb_mosi_bits", {24'd0, a_cap}, {24'd0, mosi_q.pop_front()});
      end
    end
    dsr_prev = dsr;
    if (b_sck !== b_sck_prev && !b_ce_seen) b_viol++;
    b_sck_prev = b_sck;
  end

  task automatic send_start(input logic [7:0] d, input logic [7:0] m, input bit push,
                            input bit do_cs, input logic cs_v);
    @(negedge clk);
    din = d; wr = 1'b1; cs_wr = do_cs; cs_val = cs_v;
    slave_byte = m; slave_ld = 1'b1;
    #1 slave_ld = 1'b0;
    if (push) begin
      exp_q.push_back(m);
      mosi_q.push_back(d);
    end
    @(posedge clk); #1;
    wr = 1'b0; cs_wr = 1'b0;
    acc_a = edge_cnt;
  endtask

  task automatic wait_done_a(input string tag, input int exp_lat);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (dsr) break;
    end
    check(tag, edge_cnt - acc_a, exp_lat);
  endtask

  task automatic cs_cmd(input logic v);
    @(negedge clk);
    cs_wr = 1'b1; cs_val = v;
    @(posedge clk); #1;
    cs_wr = 1'b0;
  endtask

  int rises_before;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst_sck", {31'd0, sck}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd1);
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_dsr", {31'd0, dsr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'h00);
    check("rst_state", {30'd0, fsm_state}, 32'd0);

    cs_cmd(1'b1);
    check("cs_assert", {31'd0, cs_n}, 32'd0);
    cs_cmd(1'b0);
    check("cs_release", {31'd0, cs_n}, 32'd1);

    send_start(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0);
    check("a5_busy", {31'd0, busy}, 32'd1);
    check("a5_mosi_msb", {31'd0, mosi}, 32'd1);
    wait_done_a("a5_latency", 33);
    check("a5_busy_done", {31'd0, busy}, 32'd0);
    check("a5_mosi_idle", {31'd0, mosi}, 32'd1);

    // Poll handshake with cs_wr on the accepting edge, then an ignored mid-byte wr.
    send_start(8'h5A, 8'hC3, 1'b1, 1'b1, 1'b1);
    check("hs_dsr_cleared", {31'd0, dsr}, 32'd0);
    check("hs_cs_same_edge", {31'd0, cs_n}, 32'd0);
    repeat (10) @(negedge clk);
    din = 8'h00; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    check("hs_busy_ignored_wr", {31'd0, busy}, 32'd1);
    check("hs_dsr_ignored_wr", {31'd0, dsr}, 32'd0);
    wait_done_a("hs_latency", 33);

    // Back-to-back random bytes, each accepted one edge after the previous dsr.
    for (int k = 0; k < 3; k++) begin
      send_start(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
      wait_done_a("rand_latency", 33);
    end

    // Gated clock enable on the DIV=1 instance.
    @(negedge clk);
    b_din = 8'hFF; b_wr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (b_ce) break;
    end
    b_wr = 1'b0;
    b_acc = b_edge_cnt;
    check("b_busy", {31'd0, b_busy}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (b_dsr) break;
    end
    check("b_latency", b_edge_cnt - b_acc, 32'd17);
    check("b_dout", {24'd0, b_dout}, 32'h00);
    check("b_mosi_bits", {24'd0, b_cap}, 32'hFF);
    check("b_no_sck_on_idle_ce", b_viol, 32'd0);

    // Reset during bit 4 aborts the byte with no dsr.
    cs_cmd(1'b1);
    send_start(8'h96, 8'h69, 1'b0, 1'b0, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rises_before = dsr_rises;
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk); #1;
    check("abort_sck", {31'd0, sck}, 32'd0);
    check("abort_mosi", {31'd0, mosi}, 32'd1);
    check("abort_cs_n", {31'd0, cs_n}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_dout", {24'd0, dout}, 32'h00);
    check("abort_state", {30'd0, fsm_state}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_dsr", {31'd0, dsr}, 32'd0);
    check("abort_no_dsr_rise", dsr_rises - rises_before, 32'd0);

`ifdef SPI_SLOWCLK_EN
    slow = 1'b1;
    send_start(8'hC1, 8'h7E, 1'b1, 1'b0, 1'b0);
    slow = 1'b0;
    wait_done_a("slow_latency", 1025);
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/spi_byte_master.md
# spi_byte_master

Byte-wide SPI master (mode 0, MSB first) that sits directly downstream of the floppy/SD block-DMA engine. It accepts one byte per write strobe, shifts it out on MOSI while shifting MISO in, and raises a data-ready level when the received byte is valid. It also owns the card chip-select line, so the SD sector path is DMA → `spi_byte_master` → SD card pins.

## Interface
- `DIV`, default 2: SCK half-period in ce-qualified clk cycles; legal range 1..255.
- `SLOW_DIV`, default 64: SCK half-period used when `slow`=1. Only present with `SPI_SLOWCLK_EN`.
- `clk`, in, 1: clock.
- `reset_n`, in, 1: synchronous, active-low reset. Dominates `ce`.
- `ce`, in, 1: clock enable. All state, including the divider, holds while `ce`=0.
- `wr`, in, 1: start-transfer strobe. Sampled on ce-qualified edges.
- `din`, in, 8: byte to transmit. Latched when `wr` is accepted.
- `dout`, out, 8: last received byte. Valid while `dsr`=1.
- `dsr`, out, 1: data-ready level.
- `busy`, out, 1: high from `wr` acceptance until `dsr` rises.
- `cs_wr`, in, 1: chip-select update strobe.
- `cs_val`, in, 1: on `cs_wr`, sets `cs_n` to `~cs_val`.
- `slow`, in, 1: selects the `SLOW_DIV` half-period. Only present with `SPI_SLOWCLK_EN`.
- `sck`, out, 1: SPI clock, idle low.
- `mosi`, out, 1: serial data out, idle high.
- `miso`, in, 1: serial data in. Must be synchronised externally if required.
- `cs_n`, out, 1: card select, active low.

## Operation
- Reset values: `sck`=0, `mosi`=1, `cs_n`=1, `dsr`=0, `busy`=0, `dout`=8'h00, state=IDLE.
- Registers:
  - `txreg[7:0]`: transmit shift register.
  - `rxreg[7:0]`: receive shift register.
  - `bitcnt[2:0]`: bit counter.
  - `divcnt[7:0]`: half-period divider.
  - `half[7:0]`: half-period reload value, latched at transfer start.
- States IDLE, LOW, HIGH, DONE; all transitions are ce-qualified.
- IDLE with `wr`=1:
  - `txreg`←`din`, `mosi`←`din[7]`, `bitcnt`←0.
  - `half`←DIV, or SLOW_DIV when `slow`=1 under the macro; `divcnt`←`half`−1.
  - `dsr`←0, `busy`←1, go to LOW.
- LOW:
  - If `divcnt`≠0, decrement it.
  - Otherwise: `sck`←1, `rxreg`←{`rxreg[6:0]`, `miso`}, `divcnt`←`half`−1, go to HIGH.
- HIGH:
  - If `divcnt`≠0, decrement it.
  - Otherwise `sck`←0. If `bitcnt`=7, go to DONE.
  - Else `bitcnt`+1, `txreg`←`txreg`<<1, `mosi`←`txreg[6]`, `divcnt`←`half`−1, go to LOW.
- DONE: `dout`←`rxreg`, `dsr`←1, `busy`←0, `mosi`←1, go to IDLE.
- `dsr` is a level. It stays 1 until the edge on which the next `wr` is accepted, and is cleared on that same edge. A caller that strobes `wr` for one cycle and then polls `dsr` therefore never sees a stale ready.
- `wr` while not in IDLE is ignored. The in-flight transfer and `dsr` are unaffected.
- `cs_wr` is honoured in any state, including mid-transfer. Sequencing CS around bytes is the caller's responsibility.
- `wr` and `cs_wr` on the same edge are both honoured.
- Reset mid-transfer aborts immediately to reset values. No `dsr` is generated.
- `slow` is sampled only at acceptance. Changing it mid-byte has no effect until the next byte.

## Timing
- Accepting edge = E0. The first SCK rise occurs at ce-edge E0+DIV.
- Each bit lasts 2·DIV ce-edges.
- The final SCK fall is at E0+16·DIV. DONE executes on the next ce-edge, so `dsr`=1 and `dout` are valid from E0+16·DIV+1.
- With DIV=1: 17 ce-edges per byte.
- MOSI changes only on SCK falling edges (or at acceptance). MISO is sampled on the same edge that drives SCK high.
- Back-to-back throughput: the next `wr` can be accepted one ce-edge after `dsr` rises.

## Configuration
- `SPI_SLOWCLK_EN` defined:
  - `slow` port and `SLOW_DIV` parameter exist.
  - `slow`=1 at acceptance uses `SLOW_DIV` (≈400 kHz SD initialisation clock).
- Not defined:
  - No `slow` port, no `SLOW_DIV`.
  - `half` is the constant DIV and its register may be optimised away.

## Test plan
- Reset, then idle 20 cycles → `sck`=0, `mosi`=1, `cs_n`=1, `dsr`=0, `busy`=0, `dout`=00.
- DIV=2, `wr` with `din`=A5, MISO model returns 3C → MOSI bits 1,0,1,0,0,1,0,1 on the SCK rises; `dsr` rises 33 ce-edges after acceptance; `dout`=3C.
- Poll handshake: pulse `wr` for one cycle with `dsr` previously 1 → `dsr`=0 on the edge after `wr`; a second `wr` mid-byte with `din`=00 is ignored and the original byte completes.
- `ce` toggling 1-of-3 cycles with DIV=1, `din`=FF, MISO=0 → 17 ce-edges to `dsr`, `dout`=00, and no SCK edge on a ce=0 cycle.
- `cs_wr`/`cs_val`=1 then 0 → `cs_n` goes 0 then 1 on the following ce-edges. Assert `reset_n`=0 at bit 4 of a byte → all outputs return to reset values and no `dsr` is produced.
- With `SPI_SLOWCLK_EN`, `slow`=1, SLOW_DIV=64 → SCK half-period is 64 ce-edges and `dsr` rises at 1025 ce-edges after acceptance.
